// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the binary/Gray counter family.
// Functions operate on MAX_DATA_WIDTH-bit values; narrower codes are
// zero-extended, which leaves their Gray/binary mapping unchanged.
package gray_pkg;

  localparam int MAX_DATA_WIDTH = 32;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [MAX_DATA_WIDTH-1:0] bin2gray(
    input logic [MAX_DATA_WIDTH-1:0] value
  );
    return value ^ (value >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_DATA_WIDTH-1:0] gray2bin(
    input logic [MAX_DATA_WIDTH-1:0] value
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result[MAX_DATA_WIDTH-1] = value[MAX_DATA_WIDTH-1];
    for (int i = MAX_DATA_WIDTH - 2; i >= 0; i--) begin
      result[i] = result[i+1] ^ value[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// binary_to_gray: purely combinational, width-parameterized binary-to-Gray
// encoder. The top bit passes through; every lower bit is the XOR of the
// binary bit and its upper neighbour.
module binary_to_gray #(
  parameter int data_width = 4
) (
  input  logic [data_width-1:0] d_in,
  output logic [data_width-1:0] d_out
);

  assign d_out[data_width-1] = d_in[data_width-1];

  generate
    for (genvar gi = 0; gi < data_width - 1; gi++) begin : g_xor
      assign d_out[gi] = d_in[gi+1] ^ d_in[gi];
    end
  endgenerate

endmodule

// File: rtl/binary_to_gray_counter.sv
// binary_to_gray_counter: registered binary counter presented as Gray code
// straight from a flop, suitable for pointers crossing clock domains.
// Load has priority over increment; wrap pulses for one cycle after an
// increment from all-ones.
// Optional macro BIN_OUT_EN adds the bin_out port carrying the registered
// binary count for same-domain arithmetic.
module binary_to_gray_counter
  import gray_pkg::*;
#(
  parameter int data_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [data_width-1:0] d_in,
  input  logic                  inc,
  output logic [data_width-1:0] d_out,
`ifdef BIN_OUT_EN
  output logic [data_width-1:0] bin_out,
`endif
  output logic                  wrap
);

  logic [data_width-1:0] bin_q;
  logic [data_width-1:0] bin_next;
  logic [data_width-1:0] gray_next;
  logic                  wrap_next;

  // Next binary count: load wins, then increment, otherwise hold.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = d_in;
    end else if (inc) begin
      bin_next  = bin_q + 1'b1;
      wrap_next = &bin_q;
    end
  end

  // Gray encoding happens before the register so d_out is glitch-free.
  binary_to_gray #(
    .data_width(data_width)
  ) u_encoder (
    .d_in (bin_next),
    .d_out(gray_next)
  );

  // Binary count, Gray output and wrap pulse all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      d_out <= '0;
      wrap  <= 1'b0;
    end else begin
      bin_q <= bin_next;
      d_out <= gray_next;
      wrap  <= wrap_next;
    end
  end

`ifdef BIN_OUT_EN
  assign bin_out = bin_q;
`endif

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// tb_binary_to_gray_counter: directed checks on a 4-bit counter followed by
// a randomized sweep of 2-bit and 8-bit counters against an integer model.
// With BIN_OUT_EN defined the bin_out ports are checked as well.
module tb_binary_to_gray_counter;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       load4 = 1'b0, inc4 = 1'b0;
  logic [3:0] din4 = '0;
  logic [3:0] dout4;
  logic       wrap4;

  logic       load2 = 1'b0, inc2 = 1'b0;
  logic [1:0] din2 = '0;
  logic [1:0] dout2;
  logic       wrap2;

  logic       load8 = 1'b0, inc8 = 1'b0;
  logic [7:0] din8 = '0;
  logic [7:0] dout8;
  logic       wrap8;

`ifdef BIN_OUT_EN
  logic [3:0] bout4;
  logic [1:0] bout2;
  logic [7:0] bout8;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  binary_to_gray_counter #(.data_width(4)) u4 (
    .clk(clk), .rst_n(rst_n), .load(load4), .d_in(din4), .inc(inc4),
    .d_out(dout4),
`ifdef BIN_OUT_EN
    .bin_out(bout4),
`endif
    .wrap(wrap4)
  );

  binary_to_gray_counter #(.data_width(2)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .d_in(din2), .inc(inc2),
    .d_out(dout2),
`ifdef BIN_OUT_EN
    .bin_out(bout2),
`endif
    .wrap(wrap2)
  );

  binary_to_gray_counter #(.data_width(8)) u8 (
    .clk(clk), .rst_n(rst_n), .load(load8), .d_in(din8), .inc(inc8),
    .d_out(dout8),
`ifdef BIN_OUT_EN
    .bin_out(bout8),
`endif
    .wrap(wrap8)
  );

  // Reference Gray value of an integer count.
  function automatic int gref(input int c);
    return c ^ (c >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the 4-bit instance, let one edge pass, sample 1 time unit later.
  task automatic step4(input logic ld, input logic in, input logic [3:0] d);
    load4 = ld;
    inc4  = in;
    din4  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev;
    int cnt;
    int c2, c8, e2, e8;
    logic ew2, ew8;
    logic l2, i2, l8, i8;
    logic [1:0] d2;
    logic [7:0] d8;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset_dout", 32'(dout4), 32'h0);
    check("reset_wrap", 32'(wrap4), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First counts after release
    step4(1'b0, 1'b1, 4'h0); check("first_1", 32'(dout4), 32'h1);
    $display("inc -> d_out=%b", dout4);
    step4(1'b0, 1'b1, 4'h0); check("first_2", 32'(dout4), 32'h3);
    $display("inc -> d_out=%b", dout4);
    step4(1'b0, 1'b1, 4'h0); check("first_3", 32'(dout4), 32'h2);
    $display("inc -> d_out=%b", dout4);

    // Full cycle from zero with single-bit steps and one wrap pulse
    step4(1'b1, 1'b0, 4'h0);
    check("load0_dout", 32'(dout4), 32'h0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      prev = dout4;
      step4(1'b0, 1'b1, 4'h0);
      check("cycle_wrap", 32'(wrap4), 32'(cnt == 15));
      cnt = (cnt + 1) % 16;
      check("cycle_dout", 32'(dout4), 32'(gref(cnt)));
      check("cycle_1bit", 32'($countones(dout4 ^ prev)), 32'd1);
      $display("inc count=%0d d_out=%b wrap=%b", cnt, dout4, wrap4);
    end

    // Load and load-over-inc priority
    step4(1'b1, 1'b0, 4'b1010); check("load_1010", 32'(dout4), 32'hF);
    $display("load 1010 -> d_out=%b", dout4);
    step4(1'b1, 1'b1, 4'b0101); check("load_prio", 32'(dout4), 32'h7);
    check("load_prio_wrap", 32'(wrap4), 32'h0);
    $display("load+inc 0101 -> d_out=%b", dout4);

    // Load at wrap boundary
    step4(1'b1, 1'b0, 4'hF); check("load_ff_dout", 32'(dout4), 32'h8);
    check("load_ff_wrap", 32'(wrap4), 32'h0);
    step4(1'b0, 1'b1, 4'h0); check("wrap_dout", 32'(dout4), 32'h0);
    check("wrap_pulse", 32'(wrap4), 32'h1);
    step4(1'b0, 1'b1, 4'h0); check("post_wrap_dout", 32'(dout4), 32'h1);
    check("post_wrap_pulse", 32'(wrap4), 32'h0);
    $display("load 1111, inc, inc -> d_out=%b", dout4);

    // Loading zero from all-ones never pulses wrap
    step4(1'b1, 1'b0, 4'hF);
    step4(1'b1, 1'b0, 4'h0); check("load_zero_wrap", 32'(wrap4), 32'h0);
    check("load_zero_dout", 32'(dout4), 32'h0);

    // X on d_in is ignored when load is low
    step4(1'b0, 1'b1, 4'bxxxx); check("x_din", 32'(dout4), 32'h1);

    // Async reset mid-count at count 6
    step4(1'b1, 1'b0, 4'd6); check("count6", 32'(dout4), 32'h5);
    inc4 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(dout4), 32'h0);
    check("async_rst_wrap", 32'(wrap4), 32'h0);
    @(posedge clk); #1;
    check("rst_held_dout", 32'(dout4), 32'h0);
    rst_n = 1'b1;
    step4(1'b0, 1'b1, 4'h0); check("resume_1", 32'(dout4), 32'h1);
    $display("reset mid-count, resume -> d_out=%b", dout4);

    // Async reset discards an active wrap pulse
    step4(1'b1, 1'b0, 4'hF);
    step4(1'b0, 1'b1, 4'h0); check("pend_wrap", 32'(wrap4), 32'h1);
    inc4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("pend_wrap_clr", 32'(wrap4), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step4(1'b0, 1'b0, 4'h0);
    check("pend_wrap_idle", 32'(wrap4), 32'h0);

    // Randomized sweep on widths 2 and 8
    c2 = 0;
    c8 = 0;
    for (int k = 0; k < 1000; k++) begin
      l2 = ($urandom_range(0, 7) == 0);
      i2 = $urandom_range(0, 1);
      d2 = 2'($urandom);
      l8 = ($urandom_range(0, 15) == 0);
      i8 = ($urandom_range(0, 3) != 0);
      d8 = 8'($urandom);
      load2 = l2; inc2 = i2; din2 = d2;
      load8 = l8; inc8 = i8; din8 = d8;
      ew2 = !l2 && i2 && (c2 == 3);
      ew8 = !l8 && i8 && (c8 == 255);
      e2 = l2 ? int'(d2) : (i2 ? (c2 + 1) % 4 : c2);
      e8 = l8 ? int'(d8) : (i8 ? (c8 + 1) % 256 : c8);
      @(posedge clk); #1;
      c2 = e2;
      c8 = e8;
      check("rnd2_dout", 32'(dout2), 32'(gref(c2)));
      check("rnd2_wrap", 32'(wrap2), 32'(ew2));
      check("rnd2_decode", gray2bin(32'(dout2)), 32'(c2));
      check("rnd8_dout", 32'(dout8), 32'(gref(c8)));
      check("rnd8_wrap", 32'(wrap8), 32'(ew8));
      check("rnd8_decode", gray2bin(32'(dout8)), 32'(c8));
`ifdef BIN_OUT_EN
      check("rnd2_bin", 32'(bout2), gray2bin(32'(dout2)));
      check("rnd8_bin", 32'(bout8), gray2bin(32'(dout8)));
      check("rnd8_bin_model", 32'(bout8), 32'(c8));
`endif
      $display("rnd %0d w2 ld=%b inc=%b cnt=%0d d_out=%b | w8 ld=%b inc=%b cnt=%0d d_out=%b",
               k, l2, i2, c2, dout2, l8, i8, c8, dout8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/binary_to_gray_counter.md
Name: binary_to_gray_counter

Overview:
- Registered binary counter that presents its count as Gray code on a glitch-free register output.
- Forward-direction partner of the team's combinational Gray-to-binary decoder.
- Generates Gray-coded pointers that cross clock domains, e.g. async FIFO write/read pointers; the far side decodes them back to binary.
- Supports synchronous load of a binary start value, increment enable, and a one-cycle wrap pulse.

Parameters:
- data_width, 4, counter and code width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load strobe; captures d_in as the new binary count.
- d_in  input  data_width  binary load value, sampled only when load=1.
- inc  input  1  increment enable; advances the count by one.
- d_out  output  data_width  registered Gray code of the current count.
- wrap  output  1  registered pulse, high for one cycle after the count wraps from all-ones to zero.

Behaviour:
- Reset: rst_n low asynchronously forces bin_q=0, d_out=0, wrap=0, independent of clk. Release is synchronous to the next clk edge; the first inc after release yields d_out=1.
- State: internal binary register bin_q (data_width bits) and output register d_out.
  - d_out is always driven directly from a flop, never from combinational XOR logic. It is loaded with bin2gray(bin_next) on the same edge that bin_q takes bin_next.
- bin_next, evaluated in priority order:
  - load=1: bin_next = d_in; inc is ignored that cycle.
  - load=0, inc=1: bin_next = bin_q + 1, modulo 2^data_width.
  - otherwise: bin_next = bin_q (hold).
- Gray rule: gray[data_width-1] = bin[data_width-1]; gray[i] = bin[i+1] XOR bin[i] for i < data_width-1.
- Latency: one cycle. A load or inc sampled at edge N is visible on d_out after edge N.
- Single-bit-change guarantee: with load=0, consecutive distinct d_out values differ in exactly one bit, including the wrap transition (e.g. 1000 -> 0000 for width 4).
- Wrap:
  - wrap is registered. It is set to 1 for exactly one cycle when load=0, inc=1 and bin_q is all-ones; otherwise it is 0.
  - load never asserts wrap, even when loading zero from all-ones.
- Boundaries:
  - Continuous inc free-runs through every wrap with no stall cycle.
  - load of all-ones followed by inc wraps normally and pulses wrap.
  - rst_n asserted mid-operation clears state within the same cycle; any pending wrap pulse is discarded.
  - d_in is don't-care when load=0; X on d_in must not propagate.

Optional Feature:
- Macro: BIN_OUT_EN.
- Defined:
  - Adds output port bin_out (data_width), driven directly from bin_q. It is the registered binary count, cycle-aligned with d_out; reset value 0.
  - Used for local (same-domain) occupancy arithmetic.
- Undefined: port absent; bin_q stays internal; functional behaviour of d_out and wrap is identical.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(value) and function gray2bin(value), width-generic via parameterized sizing.
  - The bench reference-model constant MAX_DATA_WIDTH = 32.
- Natural sub-module: binary_to_gray, a purely combinational, width-parameterized encoder (d_in binary -> d_out Gray). It is instantiated on bin_next, and its output is registered in this block.
- The counter, load/inc priority and wrap logic stay in binary_to_gray_counter.

Test Plan (data_width=4 unless noted):
- Reset/first counts: rst_n low -> d_out=0000, wrap=0; release, inc=1 for 3 cycles -> d_out sequence 0001, 0011, 0010.
- Full cycle and wrap: inc held 16 cycles from 0 -> d_out reaches 1000 at count 15, then 0000; wrap=1 on exactly that cycle only. Every step differs from the previous value by one bit (popcount of XOR = 1).
- Load and priority: load=1, d_in=1010 -> d_out=1111 next cycle. load=1 and inc=1 together with d_in=0101 -> d_out=0111 (load wins, no +1).
- Load at wrap boundary: load d_in=1111 -> d_out=1000, wrap=0; then inc -> d_out=0000, wrap=1.
- Async reset mid-count: at count 6 (d_out=0101), pulse rst_n low between edges -> d_out=0000 immediately, wrap=0; counting resumes from 0001.
- Width sweep with BIN_OUT_EN defined, data_width=2 and 8: random load/inc for 1000 cycles. Check gray2bin(d_out)==bin_out every cycle, and that d_out matches the gray_pkg reference model.
